// File: rtl/block_sequencer.sv
// Splits a message length into per-block descriptors (size, thermometer mask,
// last/full flags, index) for the byte-validity datapath.

module size2valid #(
  parameter int VALUE_SIZE   = 5,
  parameter int BUS_OUT_SIZE = 16
) (
  input  logic [VALUE_SIZE-1:0]   i_size,
  output logic [BUS_OUT_SIZE-1:0] o_valid
);

  always_comb begin
    o_valid = '0;
    for (int i = 0; i < BUS_OUT_SIZE; i++) begin
      o_valid[i] = (VALUE_SIZE'(i) < i_size);
    end
  end

endmodule

module block_sequencer #(
  parameter  int BLOCK_BYTES = 16,
  parameter  int LEN_SIZE    = 16,
  localparam int SIZE_BITS   = $clog2(BLOCK_BYTES) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LEN_SIZE-1:0]    cmd_len,
  input  logic                   cmd_empty_blk,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   abort,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [SIZE_BITS-1:0]   blk_size,
  output logic [BLOCK_BYTES-1:0] blk_mask,
  output logic                   blk_last,
  output logic                   blk_full,
  output logic [LEN_SIZE-1:0]    blk_idx,
  output logic                   busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; abort overrides both, so nothing transfers in an abort cycle.

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t              r_state;
  logic [LEN_SIZE-1:0] r_rem;
  logic [LEN_SIZE-1:0] r_idx;

  state_t              w_state_nxt;
  logic [LEN_SIZE-1:0] w_rem_nxt;
  logic [LEN_SIZE-1:0] w_idx_nxt;
  logic                w_emit;
  logic                w_last;
  logic [LEN_SIZE-1:0] w_size_wide;

  // min(rem, BLOCK_BYTES) is formed at full length width before narrowing.
  assign w_emit      = (r_state == ST_EMIT);
  assign w_last      = (r_rem <= LEN_SIZE'(BLOCK_BYTES));
  assign w_size_wide = w_last ? r_rem : LEN_SIZE'(BLOCK_BYTES);

  assign cmd_ready = (r_state == ST_IDLE) & ~abort;
  assign blk_valid = w_emit;
  assign busy      = w_emit;
  assign blk_size  = w_emit ? w_size_wide[SIZE_BITS-1:0] : '0;
  assign blk_last  = w_emit & w_last;
  assign blk_full  = w_emit & (w_size_wide == LEN_SIZE'(BLOCK_BYTES));
  assign blk_idx   = w_emit ? r_idx : '0;

  size2valid #(
    .VALUE_SIZE  (SIZE_BITS),
    .BUS_OUT_SIZE(BLOCK_BYTES)
  ) u_mask (
    .i_size (blk_size),
    .o_valid(blk_mask)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            w_rem_nxt = cmd_len;
            w_idx_nxt = '0;
            // A zero-length command without the empty-block request is consumed silently.
            if ((cmd_len != '0) || cmd_empty_blk) w_state_nxt = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            w_rem_nxt = r_rem - w_size_wide;
            w_idx_nxt = r_idx + LEN_SIZE'(1);
            if (w_last) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer (BLOCK_BYTES=16, LEN_SIZE=16): descriptor
// table plus hand sequences for back-pressure, abort, reset and long messages.

module tb_block_sequencer;

  localparam int BB = 16;
  localparam int LS = 16;
  localparam int SB = 5;

  logic          clk;
  logic          rst_n;
  logic [LS-1:0] cmd_len;
  logic          cmd_empty_blk;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          abort;
  logic          blk_valid;
  logic          blk_ready;
  logic [SB-1:0] blk_size;
  logic [BB-1:0] blk_mask;
  logic          blk_last;
  logic          blk_full;
  logic [LS-1:0] blk_idx;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  block_sequencer #(.BLOCK_BYTES(BB), .LEN_SIZE(LS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_len      (cmd_len),
    .cmd_empty_blk(cmd_empty_blk),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .abort        (abort),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_size     (blk_size),
    .blk_mask     (blk_mask),
    .blk_last     (blk_last),
    .blk_full     (blk_full),
    .blk_idx      (blk_idx),
    .busy         (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          first;
    logic [LS-1:0] len;
    logic          empty;
    int            idx;
    int            size;
    logic [BB-1:0] mask;
    logic          last;
    logic          full;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_desc(input string tag, input int idx, input int size,
                          input logic [BB-1:0] mask, input logic last, input logic full);
    chk($sformatf("%s.valid", tag), 32'(blk_valid), 32'd1);
    chk($sformatf("%s.idx",   tag), 32'(blk_idx),   32'(idx));
    chk($sformatf("%s.size",  tag), 32'(blk_size),  32'(size));
    chk($sformatf("%s.mask",  tag), 32'(blk_mask),  32'(mask));
    chk($sformatf("%s.last",  tag), 32'(blk_last),  32'(last));
    chk($sformatf("%s.full",  tag), 32'(blk_full),  32'(full));
    chk($sformatf("%s.cmd_ready", tag), 32'(cmd_ready), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s.valid", tag),     32'(blk_valid), 32'd0);
    chk($sformatf("%s.busy", tag),      32'(busy),      32'd0);
    chk($sformatf("%s.cmd_ready", tag), 32'(cmd_ready), 32'd1);
    chk($sformatf("%s.size", tag),      32'(blk_size),  32'd0);
    chk($sformatf("%s.mask", tag),      32'(blk_mask),  32'd0);
    chk($sformatf("%s.last", tag),      32'(blk_last),  32'd0);
    chk($sformatf("%s.idx", tag),       32'(blk_idx),   32'd0);
  endtask

  // driver: called #1 after a rising edge; returns #1 after the accept edge
  task automatic issue_cmd(input string tag, input logic [LS-1:0] len, input logic empty);
    cmd_len       = len;
    cmd_empty_blk = empty;
    cmd_valid     = 1'b1;
    @(negedge clk);
    chk($sformatf("%s.accept_ready", tag), 32'(cmd_ready), 32'd1);
    chk($sformatf("%s.pre_valid", tag),    32'(blk_valid), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid     = 1'b0;
    cmd_len       = '0;
    cmd_empty_blk = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'd40, 1'b0, 0, 16, 16'hFFFF, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 16'd40, 1'b0, 1, 16, 16'hFFFF, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 16'd40, 1'b0, 2,  8, 16'h00FF, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'd32, 1'b0, 0, 16, 16'hFFFF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 16'd32, 1'b0, 1, 16, 16'hFFFF, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 16'd0,  1'b1, 0,  0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'd17, 1'b0, 0, 16, 16'hFFFF, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'd17, 1'b0, 1,  1, 16'h0001, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'd16, 1'b0, 0, 16, 16'hFFFF, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 16'd15, 1'b0, 0, 15, 16'h7FFF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'd2,  1'b0, 0,  2, 16'h0003, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'd33, 1'b1, 0, 16, 16'hFFFF, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_len = '0; cmd_empty_blk = 1'b0; cmd_valid = 1'b0;
    abort = 1'b0; blk_ready = 1'b0;
    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // table: descriptors with blk_ready held high
    blk_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].first) issue_cmd($sformatf("vec%0d", v), vecs[v].len, vecs[v].empty);
      @(negedge clk);
      chk_desc($sformatf("vec%0d", v), vecs[v].idx, vecs[v].size, vecs[v].mask,
               vecs[v].last, vecs[v].full);
      step();
    end
    // vec11 (len 33) still has two descriptors pending
    @(negedge clk);
    chk_desc("len33.i1", 1, 16, 16'hFFFF, 1'b0, 1'b1);
    step();
    @(negedge clk);
    chk_desc("len33.i2", 2, 1, 16'h0001, 1'b1, 1'b0);
    step();
    @(negedge clk);
    chk_idle("after_table");
    step();

    // zero length, no empty block: consumed with no descriptor
    issue_cmd("zero_noblk", 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("zero_noblk.c%0d", i));
      step();
    end

    // back-pressure: len 5 held for 4 cycles
    blk_ready = 1'b0;
    issue_cmd("bp", 16'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_desc($sformatf("bp.hold%0d", i), 0, 5, 16'h001F, 1'b1, 1'b0);
      step();
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk_desc("bp.take", 0, 5, 16'h001F, 1'b1, 1'b0);
    step();
    @(negedge clk);
    chk_idle("bp.done");
    step();

    // abort together with blk_ready on idx 2 of a 100-byte message
    issue_cmd("abrt", 16'd100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_desc($sformatf("abrt.i%0d", i), i, 16, 16'hFFFF, 1'b0, 1'b1);
      step();
    end
    abort = 1'b1;
    @(negedge clk);
    chk_desc("abrt.i2", 2, 16, 16'hFFFF, 1'b0, 1'b1);
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("abrt.after%0d", i));
      step();
    end
    issue_cmd("post_abrt", 16'd3, 1'b0);
    @(negedge clk);
    chk_desc("post_abrt", 0, 3, 16'h0007, 1'b1, 1'b0);
    step();

    // abort in IDLE blocks command acceptance
    abort = 1'b1; cmd_valid = 1'b1; cmd_len = 16'd8;
    @(negedge clk);
    chk("idle_abort.cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    @(negedge clk);
    chk_idle("idle_abort.no_accept");
    step();

    // long message: 261 bytes = 17 descriptors, last holds 5 bytes
    issue_cmd("long", 16'h0105, 1'b0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 16) chk_desc($sformatf("long.i%0d", i), i, 16, 16'hFFFF, 1'b0, 1'b1);
      else        chk_desc($sformatf("long.i%0d", i), i, 5, 16'h001F, 1'b1, 1'b0);
      step();
    end
    @(negedge clk);
    chk_idle("long.done");
    step();

    // reset asserted mid-message drops it immediately
    issue_cmd("rst_mid", 16'd40, 1'b0);
    @(negedge clk);
    chk_desc("rst_mid.i0", 0, 16, 16'hFFFF, 1'b0, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid.async");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid.after");
    step();
    issue_cmd("rst_post", 16'd1, 1'b0);
    @(negedge clk);
    chk_desc("rst_post", 0, 1, 16'h0001, 1'b1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_sequencer.md
# block_sequencer

Segmentation controller in front of the byte-validity datapath of the mode. It accepts one length command (total message bytes) and emits one descriptor per data block. Each descriptor carries the block's byte count, a thermometer byte-validity mask, a last flag and a full flag. Downstream absorb/squeeze logic consumes the descriptors to decide padding and final-block handling.

## Interface
- BLOCK_BYTES, 16, bytes per data block; power of two, ≥2
- LEN_SIZE, 16, width of the message length in bytes
- SIZE_BITS, log2(BLOCK_BYTES)+1, width of the per-block byte count (derived localparam, not overridable)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_len  in  LEN_SIZE  total message length in bytes
- cmd_empty_blk  in  1  when cmd_len=0: 1 = emit one empty descriptor, 0 = emit none
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- abort  in  1  synchronous flush to idle
- blk_valid  out  1  descriptor present
- blk_ready  in  1  descriptor consumed when blk_valid&blk_ready
- blk_size  out  SIZE_BITS  valid bytes in the block, 0..BLOCK_BYTES
- blk_mask  out  BLOCK_BYTES  bit i = 1 iff i < blk_size
- blk_last  out  1  final block of the message
- blk_full  out  1  blk_size == BLOCK_BYTES
- blk_idx  out  LEN_SIZE  block index within message, from 0
- busy  out  1  state != IDLE

## Operation
- Registers: state (IDLE, EMIT), rem[LEN_SIZE-1:0] (bytes still to describe), idx[LEN_SIZE-1:0].
- IDLE: cmd_ready = ~abort. On command accept:
  - rem ← cmd_len, idx ← 0.
  - If cmd_len=0 and cmd_empty_blk=0: stay in IDLE. The command is consumed and no descriptor is produced.
  - Otherwise: go to EMIT.
- EMIT: cmd_ready=0, blk_valid=1.
  - blk_size = min(rem, BLOCK_BYTES), compared at full LEN_SIZE width, with no truncation before the compare.
  - blk_last = (rem ≤ BLOCK_BYTES).
  - blk_full = (blk_size == BLOCK_BYTES).
  - blk_idx = idx.
- blk_mask: produced by the size2valid thermometer decoder, instantiated with VALUE_SIZE=SIZE_BITS and BUS_OUT_SIZE=BLOCK_BYTES, input blk_size.
- Descriptor handshake in EMIT:
  - rem ← rem − blk_size, idx ← idx+1.
  - If blk_last: go to IDLE.
- Exact multiple of BLOCK_BYTES: the final descriptor is full with blk_last=1. No trailing empty block is produced.
- Empty descriptor (cmd_len=0, cmd_empty_blk=1): blk_size=0, blk_mask=0, blk_last=1, blk_full=0, blk_idx=0.
- blk_size, blk_mask, blk_last, blk_full and blk_idx are forced to 0 whenever blk_valid=0.
- abort=1, any state: next state IDLE, rem←0, idx←0.
  - abort takes priority over both handshakes. A descriptor handshake in the abort cycle does not advance anything.
  - cmd_ready is 0 during abort.
- blk_ready while blk_valid=0 is ignored.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, rem=0, idx=0.
  - Output values: cmd_ready=1, blk_valid=0, busy=0, all descriptor outputs 0.
- Command accepted at edge t → blk_valid=1 in the cycle after t (1-cycle latency).
- Throughput: one descriptor per cycle while blk_ready=1.
- N = ceil(cmd_len/BLOCK_BYTES) descriptors (1 for an empty-block command).
  - With blk_ready held high, a command takes N cycles in EMIT.
- Final handshake at edge t → IDLE, cmd_ready=1 in the cycle after t. Commands do not overlap.
- Back-pressure: with blk_valid=1 and blk_ready=0, all descriptor outputs hold stable.
- Outputs are combinational from registers only. There is no combinational path from any input to any output, except abort→cmd_ready.
- rst_n asserted mid-message: the message is dropped, with no partial completion.

## Test plan
- Reset, then cmd_len=40 (BLOCK_BYTES=16), blk_ready=1 → 3 descriptors, one per cycle starting 1 cycle after accept:
  - idx 0: size 16, mask 0xFFFF, full=1, last=0.
  - idx 1: size 16, mask 0xFFFF, full=1, last=0.
  - idx 2: size 8, mask 0x00FF, full=0, last=1.
  - Then cmd_ready=1.
- cmd_len=32 → 2 full descriptors, the second with last=1. No empty third block.
- cmd_len=0, cmd_empty_blk=1 → one descriptor: size 0, mask 0, last=1, full=0.
- cmd_len=0, cmd_empty_blk=0 → no blk_valid. cmd_ready stays 1.
- cmd_len=5 with blk_ready low for 4 cycles → size 5, mask 0x001F, last=1 held stable, consumed on the first ready.
- cmd_len=100, abort asserted together with blk_ready during idx 2 → IDLE next cycle, no further descriptors.
  - A following cmd_len=3 starts at idx 0.
- Reset asserted during EMIT → immediate blk_valid=0, cmd_ready=1.
